btn_led_ctrl: RTL

Parametrised multi-channel button-to-LED controller for the iCEBreaker board. It registers N_CH raw button pins through a two-flop synchroniser and a per-channel debouncer, then drives each LED in a per-channel mode: follow, toggle-on-press, or blink-while-held. A one-cycle press strobe per channel is exported for downstream logic. The block sits between the SB_IO input pins and the SB_IO output pins.

---
 rtl/btn_led_pkg.sv | 12 +
 rtl/btn_led_if.sv | 20 ++
 rtl/btn_debounce.sv | 51 +++++
 rtl/btn_led_ctrl.sv | 94 +++++++++
 4 files changed

// File: rtl/btn_led_pkg.sv
// btn_led_pkg: shared definitions for the button-to-LED controller.
// Contents: per-channel LED mode encoding (2 bits per channel on MODE).
package btn_led_pkg;

   typedef enum logic [1:0] {
      MODE_FOLLOW = 2'b00,  // LED mirrors the debounced button
      MODE_TOGGLE = 2'b01,  // LED shows the press-toggled state
      MODE_BLINK  = 2'b10,  // LED blinks while the button is held
      MODE_RSVD   = 2'b11   // reserved, treated as follow
   } mode_e;

endpackage

// File: rtl/btn_led_if.sv
// btn_led_if: button/mode/LED bundle between the pin-side logic and the
// controller.
//   BTN   [N_CH-1:0]   raw button levels, 1 = pressed
//   MODE  [2*N_CH-1:0] per-channel mode, bits [2i+1:2i]
//   LED   [N_CH-1:0]   LED drive, 1 = on
//   PRESS [N_CH-1:0]   one-cycle press strobe per channel
// master: drives BTN/MODE, observes LED/PRESS. slave: the controller.
interface btn_led_if #(
   parameter int unsigned N_CH = 3
);

   logic [N_CH-1:0]   BTN;
   logic [2*N_CH-1:0] MODE;
   logic [N_CH-1:0]   LED;
   logic [N_CH-1:0]   PRESS;

   modport master (output BTN, output MODE, input LED, input PRESS);
   modport slave  (input BTN, input MODE, output LED, output PRESS);

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: one button channel -- two-flop synchroniser, debouncer and
// rising-edge detect on the debounced level.
//   clk, rst : clock, synchronous active-high reset
//   btn      : raw asynchronous button level
//   stable   : debounced level (registered)
//   rise     : combinational, high in the cycle after stable went 0->1
// A change on the synchronised input is accepted only after it has differed
// from stable for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic stable,
   output logic rise
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          stable_prev;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1       <= 1'b0;
         sync2       <= 1'b0;
         stable      <= 1'b0;
         stable_prev <= 1'b0;
         cnt         <= '0;
      end else begin
         sync1       <= btn;
         sync2       <= sync1;
         stable_prev <= stable;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign rise = stable & ~stable_prev;

endmodule

// File: rtl/btn_led_ctrl.sv
// btn_led_ctrl: N_CH-channel button-to-LED controller.
//   CLK : system clock
//   RST : synchronous active-high reset
//   bus : btn_led_if slave -- BTN in, MODE in, LED out (registered),
//         PRESS out (registered one-cycle strobe on debounced press)
// Per channel: debounce, then LED by mode: follow, toggle-on-press, or
// blink-while-held (reserved mode behaves as follow).
// Build option: BTN_LED_BLINK_EN adds the shared blink counter; without it
// blink mode behaves as follow.
module btn_led_ctrl
   import btn_led_pkg::*;
#(
   parameter int unsigned N_CH            = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 120000,
   parameter int unsigned BLINK_HALF      = 3000000
) (
   input logic       CLK,
   input logic       RST,
   btn_led_if.slave  bus
);

   if (N_CH < 1 || DEBOUNCE_CYCLES < 1 || BLINK_HALF < 1) begin : g_param_check
      $error("btn_led_ctrl: N_CH, DEBOUNCE_CYCLES and BLINK_HALF must be >= 1");
   end

   logic [N_CH-1:0] stable;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] tgl;
   logic [N_CH-1:0] tgl_next;
   logic [N_CH-1:0] led_next;
   logic            blink_phase;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk    (CLK),
         .rst    (RST),
         .btn    (bus.BTN[i]),
         .stable (stable[i]),
         .rise   (rise[i])
      );
   end

`ifdef BTN_LED_BLINK_EN
   localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

   logic [BW-1:0] blink_cnt;

   // Free-running and shared by all channels; not aligned to any press.
   always_ff @(posedge CLK) begin
      if (RST) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end
`else
   // Phase held high so blink mode reduces to follow.
   assign blink_phase = 1'b1;
`endif

   // Toggle state flips on every press whatever the mode; the LED in toggle
   // mode shows the post-flip value so it changes in the same cycle as PRESS.
   always_comb begin
      tgl_next = tgl ^ rise;
      led_next = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         case (mode_e'(bus.MODE[2*i +: 2]))
            MODE_TOGGLE: led_next[i] = tgl_next[i];
            MODE_BLINK:  led_next[i] = stable[i] & blink_phase;
            default:     led_next[i] = stable[i];
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         tgl       <= '0;
         bus.LED   <= '0;
         bus.PRESS <= '0;
      end else begin
         tgl       <= tgl_next;
         bus.LED   <= led_next;
         bus.PRESS <= rise;
      end
   end

endmodule
